// File: rtl/axis_uart_tx_sched_if.sv
// AXI-Stream byte channel feeding the UART transmit scheduler.
interface axis_uart_tx_sched_if;
  logic [7:0] s_tdata;
  logic       s_tvalid;
  logic       s_tlast;
  logic       s_tready;

  modport master (output s_tdata, s_tvalid, s_tlast, input s_tready);
  modport slave  (input s_tdata, s_tvalid, s_tlast, output s_tready);
endinterface

// File: rtl/axis_uart_tx_sched.sv
// UART transmit scheduler: pulls stream bytes, launches the serializer and
// inserts programmed inter-byte / inter-frame idle gaps counted in bit times.
module axis_uart_tx_sched (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 softRst,
  input  logic                 powerDown,
  input  logic [3:0]           mode,
  input  logic [15:0]          txByte_nop,
  input  logic [15:0]          txFrame_nop,
  input  logic [23:0]          maxBytesPerFrame,
  input  logic                 bitTick,
  axis_uart_tx_sched_if.slave  s_axis,
  output logic [7:0]           tx_data,
  output logic                 tx_start,
  input  logic                 tx_done,
  output logic                 txBytesInt,
  output logic                 txFrameInt,
  output logic                 busy
);

  typedef enum logic [2:0] {IDLE, START, SEND, BYTE_GAP, FRAME_GAP} state_t;

  state_t      state_q, state_d;
  logic [23:0] byte_cnt_q, byte_cnt_d, byte_cnt_inc;
  logic [15:0] gap_cnt_q, gap_cnt_d;
  logic        frame_end_q, frame_end_d;
  logic        abort_q, abort_d;
  logic [7:0]  tx_data_d;
  logic        tx_start_d, bytes_int_d, frame_int_d;
  logic        accept;
  logic        mode_unused;

  assign mode_unused     = ^mode[2:0];
  assign s_axis.s_tready = (state_q == IDLE) & ~rst & ~softRst & ~powerDown;
  assign accept          = s_axis.s_tvalid & s_axis.s_tready;
  assign busy            = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      byte_cnt_q  <= '0;
      gap_cnt_q   <= '0;
      frame_end_q <= 1'b0;
      abort_q     <= 1'b0;
      tx_data     <= '0;
      tx_start    <= 1'b0;
      txBytesInt  <= 1'b0;
      txFrameInt  <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      frame_end_q <= frame_end_d;
      abort_q     <= abort_d;
      tx_data     <= tx_data_d;
      tx_start    <= tx_start_d;
      txBytesInt  <= bytes_int_d;
      txFrameInt  <= frame_int_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    frame_end_d  = frame_end_q;
    abort_d      = abort_q;
    tx_data_d    = tx_data;
    tx_start_d   = 1'b0;
    bytes_int_d  = 1'b0;
    frame_int_d  = 1'b0;
    byte_cnt_inc = byte_cnt_q + 24'd1;

    case (state_q)
      IDLE: begin
        if (softRst) begin
          byte_cnt_d  = '0;
          gap_cnt_d   = '0;
          frame_end_d = 1'b0;
        end else if (accept) begin
          tx_data_d   = s_axis.s_tdata;
          frame_end_d = s_axis.s_tlast |
                        ((maxBytesPerFrame != '0) & (byte_cnt_inc == maxBytesPerFrame));
          byte_cnt_d  = frame_end_d ? '0 : byte_cnt_inc;
          tx_start_d  = 1'b1;
          state_d     = START;
        end
      end

      START: begin
        if (softRst) abort_d = 1'b1;
        state_d = SEND;
      end

      SEND: begin
        // A soft reset seen while the byte is in flight is held until tx_done
        if (softRst) abort_d = 1'b1;
        if (tx_done) begin
          bytes_int_d = 1'b1;
          frame_int_d = frame_end_q;
          if (abort_q | softRst) begin
            state_d     = IDLE;
            byte_cnt_d  = '0;
            gap_cnt_d   = '0;
            frame_end_d = 1'b0;
            abort_d     = 1'b0;
          end else if (frame_end_q & mode[3] & (txFrame_nop != '0)) begin
            state_d   = FRAME_GAP;
            gap_cnt_d = txFrame_nop;
          end else if (~frame_end_q & mode[3] & (txByte_nop != '0)) begin
            state_d   = BYTE_GAP;
            gap_cnt_d = txByte_nop;
          end else begin
            state_d = IDLE;
          end
        end
      end

      BYTE_GAP, FRAME_GAP: begin
        if (softRst) begin
          state_d     = IDLE;
          byte_cnt_d  = '0;
          gap_cnt_d   = '0;
          frame_end_d = 1'b0;
        end else if (bitTick) begin
          gap_cnt_d = gap_cnt_q - 16'd1;
          if (gap_cnt_q == 16'd1) state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_axis_uart_tx_sched.sv
// Bench for axis_uart_tx_sched: per-cycle comparison against a counter-based
// behavioural model plus directed scenarios with literal expectations.
module tb_axis_uart_tx_sched;

  logic        clk = 1'b0;
  logic        rst, softRst, powerDown, bitTick, tx_done;
  logic [3:0]  mode;
  logic [15:0] byte_nop, frame_nop;
  logic [23:0] max_bytes;
  logic [7:0]  tx_data;
  logic        tx_start, txBytesInt, txFrameInt, busy;

  always #5 clk = ~clk;

  axis_uart_tx_sched_if s_axis ();

  axis_uart_tx_sched dut (
    .clk              (clk),
    .rst              (rst),
    .softRst          (softRst),
    .powerDown        (powerDown),
    .mode             (mode),
    .txByte_nop       (byte_nop),
    .txFrame_nop      (frame_nop),
    .maxBytesPerFrame (max_bytes),
    .bitTick          (bitTick),
    .s_axis           (s_axis),
    .tx_data          (tx_data),
    .tx_start         (tx_start),
    .tx_done          (tx_done),
    .txBytesInt       (txBytesInt),
    .txFrameInt       (txFrameInt),
    .busy             (busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Baud tick every third cycle while enabled
  bit tick_en = 1'b0;
  initial begin
    int phase = 0;
    bitTick = 1'b0;
    forever begin
      @(posedge clk); #1;
      phase++;
      bitTick = tick_en && (phase % 3 == 0);
    end
  end

  // Serializer stand-in: tx_done four cycles after each start pulse
  initial begin
    tx_done = 1'b0;
    forever begin
      @(posedge clk); #1;
      tx_done = 1'b0;
      if (tx_start === 1'b1) begin
        repeat (4) begin @(posedge clk); #1; end
        tx_done = 1'b1;
      end
    end
  end

  // Behavioural model: launch flag, in-flight flag, remaining gap in bit times
  bit         m_on = 1'b0;
  bit         m_start, m_fly, m_abort, m_last, m_byte_ev, m_frame_ev;
  int         m_gap, m_cnt;
  logic [7:0] m_data;

  always @(posedge clk) begin
    if (rst) begin
      m_on = 1'b1; m_start = 1'b0; m_fly = 1'b0; m_abort = 1'b0; m_last = 1'b0;
      m_byte_ev = 1'b0; m_frame_ev = 1'b0; m_gap = 0; m_cnt = 0; m_data = 8'h00;
    end else if (m_on) begin
      m_byte_ev  = 1'b0;
      m_frame_ev = 1'b0;
      if (m_start) begin
        m_start = 1'b0;
        m_fly   = 1'b1;
        if (softRst) m_abort = 1'b1;
      end else if (m_fly) begin
        if (softRst) m_abort = 1'b1;
        if (tx_done) begin
          m_fly      = 1'b0;
          m_byte_ev  = 1'b1;
          m_frame_ev = m_last;
          if (m_abort) begin
            m_abort = 1'b0; m_cnt = 0; m_last = 1'b0; m_gap = 0;
          end else if (mode[3]) begin
            m_gap = m_last ? int'(frame_nop) : int'(byte_nop);
          end
        end
      end else if (m_gap > 0) begin
        if (softRst) begin
          m_gap = 0; m_cnt = 0; m_last = 1'b0;
        end else if (bitTick) begin
          m_gap--;
        end
      end else if (softRst) begin
        m_cnt = 0; m_last = 1'b0;
      end else if (s_axis.s_tvalid && !powerDown) begin
        m_data  = s_axis.s_tdata;
        m_cnt++;
        m_last  = s_axis.s_tlast || (max_bytes != 0 && m_cnt == int'(max_bytes));
        if (m_last) m_cnt = 0;
        m_start = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_on) begin
      bit idle;
      idle = !(m_start || m_fly || m_gap > 0);
      check("s_tready",   32'(s_axis.s_tready), 32'(idle && !rst && !softRst && !powerDown));
      check("busy",       32'(busy),       32'(!idle));
      check("tx_start",   32'(tx_start),   32'(m_start));
      check("tx_data",    32'(tx_data),    32'(m_data));
      check("txBytesInt", 32'(txBytesInt), 32'(m_byte_ev));
      check("txFrameInt", 32'(txFrameInt), 32'(m_frame_ev));
    end
  end

  // Event recorder for the directed scenario expectations
  int         n_start, n_bytes;
  logic [7:0] sent_q[$];
  int         frame_at[$];
  int         gaps[$];
  bit         meas;
  int         ticks;

  always @(negedge clk) begin
    if (tx_start === 1'b1) begin n_start++; sent_q.push_back(tx_data); end
    if (txBytesInt === 1'b1) n_bytes++;
    if (txFrameInt === 1'b1) frame_at.push_back(n_bytes);
    if (txBytesInt === 1'b1) begin meas = 1'b1; ticks = 0; end
    if (meas) begin
      if (s_axis.s_tready === 1'b1) begin meas = 1'b0; gaps.push_back(ticks); end
      else if (bitTick) ticks++;
    end
  end

  task automatic clear_stats();
    n_start = 0; n_bytes = 0; meas = 1'b0; ticks = 0;
    sent_q.delete(); frame_at.delete(); gaps.delete();
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    s_axis.s_tdata  = d;
    s_axis.s_tlast  = l;
    s_axis.s_tvalid = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (s_axis.s_tready === 1'b1) break;
    end
    check("send_accept", 32'(s_axis.s_tready), 32'd1);
    @(posedge clk); #1;
    s_axis.s_tvalid = 1'b0;
    s_axis.s_tlast  = 1'b0;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (busy === 1'b0) break;
    end
    check("wait_idle", 32'(busy), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int cnt;
    logic [7:0] b2b[4];
    b2b[0] = 8'h55; b2b[1] = 8'hAA; b2b[2] = 8'h01; b2b[3] = 8'h80;

    rst = 1'b1; softRst = 1'b0; powerDown = 1'b0; mode = 4'h0;
    byte_nop = '0; frame_nop = '0; max_bytes = '0; tick_en = 1'b1;
    s_axis.s_tvalid = 1'b1; s_axis.s_tdata = 8'hEE; s_axis.s_tlast = 1'b0;
    clear_stats();

    // Reset with a pending byte
    repeat (3) begin
      @(negedge clk);
      check("rst_tready", 32'(s_axis.s_tready), 32'd0);
    end
    check("rst_tx_data", 32'(tx_data), 32'h00);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_no_start", 32'(n_start), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; s_axis.s_tvalid = 1'b0;
    @(negedge clk);
    check("tready_after_rst", 32'(s_axis.s_tready), 32'd1);
    @(posedge clk); #1;

    // Back-to-back, no gaps
    clear_stats();
    for (int i = 0; i < 4; i++) send(b2b[i], i == 3);
    wait_idle();
    check("b2b_starts", 32'(n_start), 32'd4);
    for (int i = 0; i < 4; i++)
      if (sent_q.size() > i) check("b2b_data", 32'(sent_q[i]), 32'(b2b[i]));
    check("b2b_bytes", 32'(n_bytes), 32'd4);
    check("b2b_frames", 32'(frame_at.size()), 32'd1);
    if (frame_at.size() > 0) check("b2b_frame_pos", 32'(frame_at[0]), 32'd4);

    // Gap insertion
    mode = 4'b1000; byte_nop = 16'd2; frame_nop = 16'd5;
    clear_stats();
    send(8'hA1, 1'b0); send(8'hA2, 1'b0); send(8'hA3, 1'b1);
    wait_idle();
    check("gap_count", 32'(gaps.size()), 32'd3);
    if (gaps.size() == 3) begin
      check("gap_byte1", 32'(gaps[0]), 32'd2);
      check("gap_byte2", 32'(gaps[1]), 32'd2);
      check("gap_frame", 32'(gaps[2]), 32'd5);
    end
    if (frame_at.size() > 0) check("gap_frame_pos", 32'(frame_at[0]), 32'd3);

    // Byte limit with no tlast
    mode = 4'h0; max_bytes = 24'd3;
    clear_stats();
    for (int i = 0; i < 7; i++) send(8'(8'h10 + i), 1'b0);
    wait_idle();
    check("lim_bytes", 32'(n_bytes), 32'd7);
    check("lim_frames", 32'(frame_at.size()), 32'd2);
    if (frame_at.size() == 2) begin
      check("lim_frame0", 32'(frame_at[0]), 32'd3);
      check("lim_frame1", 32'(frame_at[1]), 32'd6);
    end
    check("lim_byte_cnt", 32'(dut.byte_cnt_q), 32'd1);

    // powerDown while a byte is in flight
    max_bytes = '0;
    clear_stats();
    send(8'h3C, 1'b1);
    @(posedge clk); #1;
    powerDown = 1'b1;
    check("pd_in_flight", 32'(busy), 32'd1);
    wait_idle();
    check("pd_byte_done", 32'(n_bytes), 32'd1);
    s_axis.s_tdata = 8'hC3; s_axis.s_tlast = 1'b1; s_axis.s_tvalid = 1'b1;
    repeat (8) begin
      @(negedge clk);
      check("pd_tready", 32'(s_axis.s_tready), 32'd0);
    end
    @(posedge clk); #1;
    check("pd_blocked", 32'(n_start), 32'd1);
    powerDown = 1'b0;
    send(8'hC3, 1'b1);
    wait_idle();
    check("pd_resume", 32'(n_start), 32'd2);
    if (sent_q.size() > 1) check("pd_resume_data", 32'(sent_q[1]), 32'hC3);

    // softRst inside a long frame gap
    mode = 4'b1000; byte_nop = '0; frame_nop = 16'd100;
    clear_stats();
    send(8'h5A, 1'b1);
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (txFrameInt === 1'b1) break;
    end
    cnt = 0;
    for (int k = 0; k < 500 && cnt < 10; k++) begin
      @(negedge clk);
      if (bitTick) cnt++;
    end
    @(posedge clk); #1;
    softRst = 1'b1;
    @(negedge clk);
    check("srst_gap_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    softRst = 1'b0;
    @(negedge clk);
    check("srst_idle", 32'(busy), 32'd0);
    check("srst_tready", 32'(s_axis.s_tready), 32'd1);
    repeat (20) @(posedge clk);
    #1;
    check("srst_frames", 32'(frame_at.size()), 32'd1);
    check("srst_byte_cnt", 32'(dut.byte_cnt_q), 32'd0);

    // softRst while a byte is in flight: byte finishes, gap skipped
    frame_nop = 16'd5;
    clear_stats();
    send(8'h77, 1'b1);
    softRst = 1'b1;
    @(posedge clk); #1;
    softRst = 1'b0;
    wait_idle();
    check("srst_send_bytes", 32'(n_bytes), 32'd1);
    check("srst_send_frames", 32'(frame_at.size()), 32'd1);
    if (gaps.size() > 0) check("srst_send_nogap", 32'(gaps[0]), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/axis_uart_tx_sched.md
# axis_uart_tx_sched

Transmit-side scheduler that sits between the AXI-Stream byte input and the UART bit serializer. It pulls one byte at a time, starts the serializer, waits for completion and inserts the programmed inter-byte and inter-frame idle gaps. Gaps are counted in bit times. Frame boundaries come from `tlast` or from the `maxBytesPerFrame` limit. All configuration comes from the UART register block; the per-byte and per-frame event pulses feed its status counters.

## Interface
Parameters:
- none (all widths fixed by the register map)

Ports:
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `softRst` in 1: soft reset; aborts scheduling, see Operation.
- `powerDown` in 1: 1 stops accepting new bytes.
- `mode` in 4: only `mode[3]` is used; 1 enables gap insertion.
- `txByte_nop` in 16: inter-byte gap in bit times.
- `txFrame_nop` in 16: inter-frame gap in bit times.
- `maxBytesPerFrame` in 24: frame byte limit; 0 means unlimited (`tlast` only).
- `bitTick` in 1: one-cycle pulse per bit time, from the baud generator.
- `s_tdata` in 8: stream byte.
- `s_tvalid` in 1: stream valid.
- `s_tlast` in 1: last byte of frame.
- `s_tready` out 1: stream ready.
- `tx_data` out 8: byte to the serializer.
- `tx_start` out 1: one-cycle start pulse to the serializer.
- `tx_done` in 1: one-cycle pulse from the serializer when its stop bit(s) complete.
- `txBytesInt` out 1: one-cycle pulse per byte completed.
- `txFrameInt` out 1: one-cycle pulse per frame completed.
- `busy` out 1: state is not IDLE.

## Operation
- States: IDLE, START, SEND, BYTE_GAP, FRAME_GAP.
- **IDLE**
  - `s_tready = !rst & !softRst & !powerDown` (combinational from state).
  - On `s_tvalid & s_tready`: register `tx_data<=s_tdata`.
  - Register `frameEnd <= s_tlast | (maxBytesPerFrame!=0 & byteCnt+1==maxBytesPerFrame)`.
  - `byteCnt` (24 bit) becomes `frameEnd ? 0 : byteCnt+1`; go to START.
- **START**: `tx_start=1` for exactly this cycle; go to SEND.
- **SEND**: wait for `tx_done`. On it, pulse `txBytesInt`, and `txFrameInt` too if `frameEnd`. Then:
  - `frameEnd & mode[3] & txFrame_nop!=0` → FRAME_GAP, with `gapCnt<=txFrame_nop`.
  - `!frameEnd & mode[3] & txByte_nop!=0` → BYTE_GAP, with `gapCnt<=txByte_nop`.
  - Otherwise → IDLE.
- **BYTE_GAP / FRAME_GAP**
  - `gapCnt` (16 bit) decrements on each `bitTick`.
  - When a `bitTick` arrives with `gapCnt==1`, go to IDLE.
  - No wrap-around; 0 is never loaded.
- Configuration is sampled only at the points above. Register writes mid-gap do not change the running gap.
- `powerDown`
  - Blocks acceptance only.
  - A byte in START/SEND completes and its gap runs.
  - The block then rests in IDLE with `s_tready=0`.
- `softRst`
  - In IDLE, BYTE_GAP or FRAME_GAP: go to IDLE and clear `byteCnt`, `gapCnt` and `frameEnd` next cycle.
  - In START/SEND: the byte finishes (`tx_start` still issued, `tx_done` awaited, `txBytesInt` pulsed). The block then goes to IDLE with no gap and with counters cleared.
  - `txFrameInt` is still pulsed if `frameEnd` was set.
- `tx_done` is ignored outside SEND. `bitTick` is ignored outside gap states.

## Timing
- Reset values:
  - state IDLE; `s_tready` 0 while `rst`.
  - `tx_data` 0x00, `tx_start` 0, `txBytesInt` 0, `txFrameInt` 0, `busy` 0.
  - `byteCnt` 0, `gapCnt` 0.
- Accept handshake in cycle N → `tx_start` in cycle N+1 → SEND from N+2.
- `tx_done` in cycle M → `txBytesInt`/`txFrameInt` in cycle M+1.
  - With no gap, `s_tready` is 1 in cycle M+1.
  - With a gap of G bit times, `s_tready` returns the cycle after the G-th `bitTick` following M.
- Minimum byte period without gaps: 3 clocks plus the serializer time.
- All outputs are registered except `s_tready` and `busy`.

## Test plan
- **Reset and idle:** hold `rst` 3 cycles with `s_tvalid=1` → `s_tready=0`, no `tx_start`; after release, `s_tready=1` the next cycle.
- **Back-to-back, no gaps:** `mode=0`, 4 bytes 0x55,0xAA,0x01,0x80 with `tlast` on the 4th.
  - Expect 4 `tx_start` with matching `tx_data`.
  - Expect 4 `txBytesInt` and 1 `txFrameInt`, coincident with the 4th.
- **Gaps:** `mode[3]=1`, `txByte_nop=2`, `txFrame_nop=5`, 3-byte frame.
  - Expect exactly 2 `bitTick` between bytes 1–2 and 2–3 before `s_tready` returns.
  - Expect 5 `bitTick` after byte 3.
- **Byte limit:** `maxBytesPerFrame=3`, 7 bytes with no `tlast` → `txFrameInt` after bytes 3 and 6; `byteCnt` equals 1 at the end.
- **powerDown mid-byte:** assert `powerDown` during SEND → the byte completes and `txBytesInt` pulses, then `s_tready` stays 0; deassert → acceptance resumes.
- **softRst in FRAME_GAP:** `txFrame_nop=100`, `softRst` after 10 ticks → IDLE next cycle, `s_tready=1` after `softRst` drops, no extra `txFrameInt`.
